// File: rtl/fp_multiplier_seq.sv
// Sequential binary32 multiplier: 24-cycle shift-and-add mantissa product,
// then a one-bit-per-cycle normalizer and a packer. Rounding is truncation.
// A zero exponent field is treated as exponent 1 with hidden bit 0.
module fp_multiplier_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic [31:0] out1,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_PACK} state_t;

    state_t             r_state;
    logic               r_sign;
    logic               r_zero;
    logic               r_inf;
    logic [23:0]        r_ma;
    logic [23:0]        r_mb;
    logic signed [9:0]  r_exp;
    logic [47:0]        r_acc;
    logic [4:0]         r_cnt;
    logic [31:0]        r_out;
    logic               r_busy;
    logic               r_done;

    // Operand decode, only meaningful in the accept cycle
    logic               w_a_hid;
    logic               w_b_hid;
    logic [7:0]         w_ea;
    logic [7:0]         w_eb;
    logic [9:0]         w_exp0;
    logic               w_zero0;
    logic               w_inf0;
    logic [47:0]        w_addend;
    logic [31:0]        w_result;

    assign w_a_hid  = (in1[30:23] != 8'd0);
    assign w_b_hid  = (in2[30:23] != 8'd0);
    assign w_ea     = w_a_hid ? in1[30:23] : 8'd1;
    assign w_eb     = w_b_hid ? in2[30:23] : 8'd1;
    assign w_exp0   = {2'b00, w_ea} + {2'b00, w_eb} - 10'd127;
    assign w_zero0  = (in1[30:0] == 31'd0) || (in2[30:0] == 31'd0);
    assign w_inf0   = (in1[30:23] == 8'hFF) || (in2[30:23] == 8'hFF);
    assign w_addend = {24'd0, r_ma} << r_cnt;

    // Result selection for the PACK state, in priority order
    always_comb begin
        w_result = {r_sign, 31'd0};
        if (r_zero || (r_acc == 48'd0))
            w_result = {r_sign, 31'd0};
        else if (r_inf)
            w_result = {r_sign, 8'hFF, 23'd0};
        else if (r_exp >= 10'sd255)
            w_result = {r_sign, 8'hFF, 23'd0};
        else if (r_exp < 10'sd1)
            w_result = {r_sign, 31'd0};
        else if (!r_acc[46])
            w_result = {r_sign, 8'h00, r_acc[45:23]};
        else
            w_result = {r_sign, r_exp[7:0], r_acc[45:23]};
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sign  <= 1'b0;
            r_zero  <= 1'b0;
            r_inf   <= 1'b0;
            r_ma    <= 24'd0;
            r_mb    <= 24'd0;
            r_exp   <= 10'sd0;
            r_acc   <= 48'd0;
            r_cnt   <= 5'd0;
            r_out   <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sign  <= in1[31] ^ in2[31];
                        r_ma    <= {w_a_hid, in1[22:0]};
                        r_mb    <= {w_b_hid, in2[22:0]};
                        r_exp   <= $signed(w_exp0);
                        r_zero  <= w_zero0;
                        r_inf   <= w_inf0;
                        r_acc   <= 48'd0;
                        r_cnt   <= 5'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (r_mb[r_cnt])
                        r_acc <= r_acc + w_addend;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd23)
                        r_state <= S_NORM;
                end
                S_NORM: begin
                    if (r_acc[47]) begin
                        r_acc   <= r_acc >> 1;
                        r_exp   <= r_exp + 10'sd1;
                        r_state <= S_PACK;
                    end else if (r_acc[46] || (r_exp <= 10'sd1) || (r_acc == 48'd0)) begin
                        r_state <= S_PACK;
                    end else begin
                        r_acc <= r_acc << 1;
                        r_exp <= r_exp - 10'sd1;
                    end
                end
                S_PACK: begin
                    r_out   <= w_result;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out1 = r_out;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_fp_multiplier_seq.sv
// Directed bench for fp_multiplier_seq: hand-computed products, latencies,
// busy/done handshake, start-while-busy and asynchronous reset mid-operation.
module tb_fp_multiplier_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] out1;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    fp_multiplier_seq dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .in1  (in1),
        .in2  (in2),
        .out1 (out1),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Wait for done after an accept edge; lat counts edges after accept.
    task automatic wait_done(output int lat, output bit seen);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (done) seen = 1'b1;
        end
    endtask

    // Issue one operation and check result, latency and handshake.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_out, input int exp_lat);
        int lat;
        bit seen;
        @(negedge clk);
        in1 = a; in2 = b; start = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_busy_set"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, seen);
        chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        chk({tag, "_out"}, out1, exp_out);
        if (exp_lat > 0) chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy_clr"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        bit seen;
        int ndone;

        rst = 1'b1; start = 1'b0; in1 = 32'd0; in2 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", out1, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Main function and boundary vectors
        run_op("mul_2x3",      32'h40000000, 32'h40400000, 32'h40C00000, 26);
        // done is a single-cycle pulse
        @(posedge clk); #1;
        chk("done_pulse_1cyc", {31'd0, done}, 32'd0);
        run_op("mul_1p5sq",    32'h3FC00000, 32'h3FC00000, 32'h40100000, 26);
        run_op("neg_2x3",      32'hC0000000, 32'h40400000, 32'hC0C00000, 26);
        run_op("zero",         32'hC0000000, 32'h00000000, 32'h80000000, 0);
        run_op("overflow",     32'h7F000000, 32'h40000000, 32'h7F800000, 0);
        run_op("inf_x_zero",   32'hFF800000, 32'h00000000, 32'h80000000, 0);
        run_op("denorm_keep",  32'h00400000, 32'h3F800000, 32'h00400000, 26);
        run_op("denorm_shift", 32'h00400000, 32'h40000000, 32'h00800000, 27);
        run_op("flush",        32'h00800000, 32'h00800000, 32'h00000000, 0);

        // Start while busy is ignored
        @(negedge clk);
        in1 = 32'h40000000; in2 = 32'h40400000; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        in1 = 32'h3F800000; in2 = 32'h3F800000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, seen);
        chk("busy_start_seen", {31'd0, seen}, 32'd1);
        chk("busy_start_out", out1, 32'h40C00000);
        chk("busy_start_lat", lat, 32'd26 - 32'd6);
        ndone = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("no_second_done", ndone, 32'd0);

        // Asynchronous reset in the middle of MUL
        @(negedge clk);
        in1 = 32'h40400000; in2 = 32'h40400000; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_out", out1, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", 32'h40400000, 32'h40400000, 32'h41100000, 26);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
